// File: rtl/cb_filter_pkg.sv
// Shared types for the counting-bloom-filter controller slice.
package cb_filter_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CLEAR,
        ERROR
    } cb_ctrl_state_e;

endpackage

// File: rtl/cb_ctrl_rr_arb.sv
// Round-robin arbiter with data mux: one-hot grant, pointer advances past the winner.
module cb_ctrl_rr_arb #(
    parameter int N         = 2,
    parameter int DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [N-1:0]           req_i,
    input  logic [N*DataWidth-1:0] data_i,
    output logic [N-1:0]           gnt_o,
    output logic [DataWidth-1:0]   data_o
);

    localparam int PtrWidth = (N > 1) ? $clog2(N) : 1;

    logic [PtrWidth-1:0] ptr_q;
    logic [PtrWidth-1:0] winner;
    logic                found;

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        gnt_o  = '0;
        data_o = '0;
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                winner     = PtrWidth'(idx);
                gnt_o[idx] = 1'b1;
                data_o     = data_i[idx*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (winner == PtrWidth'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/cb_filter_ctrl.sv
// Arbitrates insert/remove requesters onto one counting bloom filter and sequences
// capacity limiting, drain-then-clear and sticky error handling.
module cb_filter_ctrl
    import cb_filter_pkg::*;
#(
    parameter int NumIncr   = 2,
    parameter int NumDecr   = 2,
    parameter int InpWidth  = 32,
    parameter int HashWidth = 4,
    parameter int MaxItems  = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumIncr-1:0]         incr_valid_i,
    input  logic [NumIncr*InpWidth-1:0] incr_data_i,
    output logic [NumIncr-1:0]         incr_ready_o,
    input  logic [NumDecr-1:0]         decr_valid_i,
    input  logic [NumDecr*InpWidth-1:0] decr_data_i,
    output logic [NumDecr-1:0]         decr_ready_o,
    input  logic                       clear_req_i,
    output logic                       clear_done_o,
    output logic                       error_o,
    output logic                       busy_o,
    output logic                       f_incr_valid_o,
    output logic [InpWidth-1:0]        f_incr_data_o,
    output logic                       f_decr_valid_o,
    output logic [InpWidth-1:0]        f_decr_data_o,
    output logic                       f_clear_o,
    input  logic [HashWidth-1:0]       f_usage_i,
    input  logic                       f_full_i,
    input  logic                       f_empty_i,
    input  logic                       f_error_i
);

    if (MaxItems < 1 || MaxItems > (2**HashWidth) - 1) begin : g_max_items_check
        $error("cb_filter_ctrl: MaxItems must be in 1..2**HashWidth-1");
    end

    localparam logic [HashWidth-1:0] MaxUsage = HashWidth'(MaxItems);

    cb_ctrl_state_e state_q;
    logic           error_q;
    logic           busy_q;
    logic           clear_q;
    logic           incr_ok;
    logic           decr_ok;

    // NOTE: grants are gated by rst_i so the combinational outputs read zero for the whole reset window.
    assign incr_ok = ~rst_i & (state_q == RUN) & ~f_full_i & (f_usage_i != MaxUsage) & ~error_q;
    assign decr_ok = ~rst_i & ((state_q == RUN) | (state_q == DRAIN));

    cb_ctrl_rr_arb #(.N(NumIncr), .DataWidth(InpWidth)) u_incr_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (incr_ok),
        .req_i  (incr_valid_i),
        .data_i (incr_data_i),
        .gnt_o  (incr_ready_o),
        .data_o (f_incr_data_o)
    );

    cb_ctrl_rr_arb #(.N(NumDecr), .DataWidth(InpWidth)) u_decr_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (decr_ok),
        .req_i  (decr_valid_i),
        .data_i (decr_data_i),
        .gnt_o  (decr_ready_o),
        .data_o (f_decr_data_o)
    );

    assign f_incr_valid_o = |incr_ready_o;
    assign f_decr_valid_o = |decr_ready_o;
    assign f_clear_o      = clear_q;
    assign clear_done_o   = clear_q;
    assign error_o        = error_q;
    assign busy_o         = busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (f_error_i) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (clear_req_i) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (f_error_i) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else if (f_empty_i && f_usage_i == '0) begin
                        state_q <= CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Filter errors are ignored here; the clear resets the filter.
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                end
                ERROR: begin
                    if (clear_req_i) begin
                        state_q <= CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cb_filter_ctrl.sv
// Directed bench for cb_filter_ctrl with a small behavioural model of the filter's usage counter.
module tb_cb_filter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  incr_valid = '0;
    logic [63:0] incr_data = '0;
    logic [1:0]  incr_ready;
    logic [1:0]  decr_valid = '0;
    logic [63:0] decr_data = '0;
    logic [1:0]  decr_ready;
    logic        clear_req = 1'b0;
    logic        clear_done;
    logic        error;
    logic        busy;
    logic        f_incr_valid;
    logic [31:0] f_incr_data;
    logic        f_decr_valid;
    logic [31:0] f_decr_data;
    logic        f_clear;
    logic [3:0]  usage;
    logic        f_error = 1'b0;
    logic        preload_en = 1'b0;
    logic [3:0]  preload_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb_filter_ctrl #(
        .NumIncr(2), .NumDecr(2), .InpWidth(32), .HashWidth(4), .MaxItems(12)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .incr_valid_i   (incr_valid),
        .incr_data_i    (incr_data),
        .incr_ready_o   (incr_ready),
        .decr_valid_i   (decr_valid),
        .decr_data_i    (decr_data),
        .decr_ready_o   (decr_ready),
        .clear_req_i    (clear_req),
        .clear_done_o   (clear_done),
        .error_o        (error),
        .busy_o         (busy),
        .f_incr_valid_o (f_incr_valid),
        .f_incr_data_o  (f_incr_data),
        .f_decr_valid_o (f_decr_valid),
        .f_decr_data_o  (f_decr_data),
        .f_clear_o      (f_clear),
        .f_usage_i      (usage),
        .f_full_i       (usage == 4'd15),
        .f_empty_i      (usage == 4'd0),
        .f_error_i      (f_error)
    );

    // Filter model: counts accepted inserts/removes, clears on f_clear, resets with the system.
    always @(posedge clk or posedge rst) begin
        if (rst) usage <= '0;
        else if (preload_en) usage <= preload_val;
        else if (f_clear) usage <= '0;
        else usage <= usage + 4'(f_incr_valid) - 4'(f_decr_valid);
    end

    task automatic preload(input logic [3:0] v);
        @(negedge clk);
        incr_valid  = '0;
        decr_valid  = '0;
        preload_en  = 1'b1;
        preload_val = v;
        @(negedge clk);
        preload_en  = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        incr_valid = 2'b11;
        decr_valid = 2'b11;
        incr_data  = {32'hCAFE_0001, 32'hCAFE_0000};
        #1;
        checks++;
        if ({incr_ready, decr_ready, f_incr_valid, f_decr_valid, f_clear, clear_done, error, busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {incr_ready, decr_ready, f_incr_valid, f_decr_valid, f_clear, clear_done, error, busy});
        end
        checks++;
        if ({f_incr_data, f_decr_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {f_incr_data, f_decr_data});
        end
        @(negedge clk);
        @(negedge clk);
        incr_valid = '0;
        decr_valid = '0;
        rst        = 1'b0;
    endtask

    task automatic test_rr_alternate;
        logic [31:0] a, b;
        logic [1:0]  exp_gnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 32'hA000_0000 + 32'(k);
            b = 32'hB000_0000 + 32'(k);
            incr_valid = 2'b11;
            incr_data  = {b, a};
            exp_gnt    = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (incr_ready !== exp_gnt || f_incr_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d] got %b/%b want %b/1", k, incr_ready, f_incr_valid, exp_gnt);
            end
            checks++;
            if (f_incr_data !== ((k % 2 == 0) ? a : b)) begin
                errors++;
                $display("FAIL rr_data[%0d] got %h want %h", k, f_incr_data, (k % 2 == 0) ? a : b);
            end
        end
        @(negedge clk);
        incr_valid = '0;
        #1;
        checks++;
        if (usage !== 4'd4) begin
            errors++;
            $display("FAIL rr_usage got %0d want 4", usage);
        end
    endtask

    task automatic test_capacity;
        preload(4'd11);
        incr_valid = 2'b01;
        incr_data  = {32'h0, 32'h1111_0000};
        #1;
        checks++;
        if (incr_ready !== 2'b01) begin
            errors++;
            $display("FAIL cap_below got %b want 01", incr_ready);
        end
        @(negedge clk);
        decr_valid = 2'b01;
        decr_data  = {32'h0, 32'h2222_0000};
        #1;
        checks++;
        if (incr_ready !== 2'b00 || decr_ready !== 2'b01) begin
            errors++;
            $display("FAIL cap_full got %b/%b want 00/01", incr_ready, decr_ready);
        end
        @(negedge clk);
        decr_valid = '0;
        #1;
        checks++;
        if (incr_ready !== 2'b01 || usage !== 4'd11) begin
            errors++;
            $display("FAIL cap_reopen got %b usage %0d want 01 usage 11", incr_ready, usage);
        end
        @(negedge clk);
        incr_valid = '0;
        #1;
        checks++;
        if (usage !== 4'd12) begin
            errors++;
            $display("FAIL cap_usage got %0d want 12", usage);
        end
    endtask

    task automatic test_simultaneous;
        preload(4'd12);
        incr_valid = 2'b11;
        decr_valid = 2'b11;
        decr_data  = {32'hD111_1111, 32'hD000_0000};
        #1;
        checks++;
        if (incr_ready !== 2'b00 || decr_ready !== 2'b10) begin
            errors++;
            $display("FAIL simul_grant got %b/%b want 00/10", incr_ready, decr_ready);
        end
        checks++;
        if (f_decr_data !== 32'hD111_1111) begin
            errors++;
            $display("FAIL simul_data got %h want d1111111", f_decr_data);
        end
        @(negedge clk);
        incr_valid = '0;
        decr_valid = '0;
        #1;
        checks++;
        if (usage !== 4'd11) begin
            errors++;
            $display("FAIL simul_usage got %0d want 11", usage);
        end
    endtask

    task automatic test_drain_clear;
        preload(4'd3);
        clear_req = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_pre_busy got %b want 0", busy);
        end
        @(negedge clk);
        incr_valid = 2'b01;
        decr_valid = 2'b01;
        for (int r = 0; r < 3; r++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || incr_ready !== 2'b00 || decr_ready !== 2'b01 || f_clear !== 1'b0) begin
                errors++;
                $display("FAIL drain_remove[%0d] got busy %b incr %b decr %b clr %b want 1/00/01/0", r, busy, incr_ready, decr_ready, f_clear);
            end
            @(negedge clk);
        end
        decr_valid = '0;
        #1;
        checks++;
        if (usage !== 4'd0 || f_clear !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got usage %0d clr %b busy %b want 0/0/1", usage, f_clear, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (f_clear !== 1'b1 || clear_done !== 1'b1 || incr_ready !== 2'b00) begin
            errors++;
            $display("FAIL drain_clear got clr %b done %b incr %b want 1/1/00", f_clear, clear_done, incr_ready);
        end
        clear_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (f_clear !== 1'b0 || clear_done !== 1'b0 || busy !== 1'b0 || incr_ready !== 2'b01) begin
            errors++;
            $display("FAIL drain_run got clr %b done %b busy %b incr %b want 0/0/0/01", f_clear, clear_done, busy, incr_ready);
        end
        incr_valid = '0;
    endtask

    task automatic test_error;
        @(negedge clk);
        f_error = 1'b1;
        #1;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_pre got %b want 0", error);
        end
        @(negedge clk);
        f_error    = 1'b0;
        incr_valid = 2'b11;
        decr_valid = 2'b11;
        #1;
        checks++;
        if (error !== 1'b1 || busy !== 1'b1 || {incr_ready, decr_ready} !== 4'b0) begin
            errors++;
            $display("FAIL err_set got err %b busy %b rdy %b want 1/1/0000", error, busy, {incr_ready, decr_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || {incr_ready, decr_ready} !== 4'b0 || f_clear !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky got err %b rdy %b clr %b want 1/0000/0", error, {incr_ready, decr_ready}, f_clear);
        end
        clear_req = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (f_clear !== 1'b1 || clear_done !== 1'b1 || {incr_ready, decr_ready} !== 4'b0) begin
            errors++;
            $display("FAIL err_clear got clr %b done %b rdy %b want 1/1/0000", f_clear, clear_done, {incr_ready, decr_ready});
        end
        clear_req  = 1'b0;
        incr_valid = '0;
        decr_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b0 || busy !== 1'b0 || f_clear !== 1'b0) begin
            errors++;
            $display("FAIL err_run got err %b busy %b clr %b want 0/0/0", error, busy, f_clear);
        end
    endtask

    task automatic test_reset_in_drain;
        preload(4'd2);
        clear_req = 1'b1;
        @(negedge clk);
        decr_valid = 2'b01;
        #1;
        checks++;
        if (busy !== 1'b1 || decr_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstd_drain got busy %b decr %b want 1/01", busy, decr_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({incr_ready, decr_ready, f_incr_valid, f_decr_valid, f_clear, clear_done, error, busy} !== 10'b0) begin
            errors++;
            $display("FAIL rstd_outputs got %b want 0", {incr_ready, decr_ready, f_incr_valid, f_decr_valid, f_clear, clear_done, error, busy});
        end
        @(negedge clk);
        rst        = 1'b0;
        clear_req  = 1'b0;
        decr_valid = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (f_clear !== 1'b0 || clear_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstd_no_clear[%0d] got clr %b done %b busy %b want 0/0/0", c, f_clear, clear_done, busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_capacity();
        test_simultaneous();
        test_drain_clear();
        test_error();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
